// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared encodings and constants for the Pong match controller
//
// Purpose: FSM state encodings, winner codes and the delay counter width
// shared by the match controller and its tick timer.
package pong_pkg;

  localparam int DELAY_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    RALLY     = 3'd2,
    POINT     = 3'd3,
    GAME_OVER = 3'd4
  } gameState_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

// File: rtl/pong_match_controller_if.sv
// rtl/pong_match_controller_if.sv - control/status bundle between frame logic and the match controller
//
// Purpose: groups the match controller's request inputs and status outputs.
// Ports (signals):
//   startPulse, pauseSwitch, tickEn, missLeft, missRight : requests into the controller
//   ballLoad, serveDirRight, moveEn                        : datapath controls
//   player1Score, player2Score, winner, gameState          : match status
// Modports: master = upstream side driving requests; slave = the controller.
interface pong_match_controller_if #(
  parameter int SCORE_W = 3
);

  logic               startPulse;
  logic               pauseSwitch;
  logic               tickEn;
  logic               missLeft;
  logic               missRight;
  logic               ballLoad;
  logic               serveDirRight;
  logic               moveEn;
  logic [SCORE_W-1:0] player1Score;
  logic [SCORE_W-1:0] player2Score;
  logic [1:0]         winner;
  logic [2:0]         gameState;

  modport master (
    output startPulse, pauseSwitch, tickEn, missLeft, missRight,
    input  ballLoad, serveDirRight, moveEn, player1Score, player2Score, winner, gameState
  );

  modport slave (
    input  startPulse, pauseSwitch, tickEn, missLeft, missRight,
    output ballLoad, serveDirRight, moveEn, player1Score, player2Score, winner, gameState
  );

endinterface

// File: rtl/pong_tick_timer.sv
// rtl/pong_tick_timer.sv - 8-bit down counter for serve and point delays
//
// Purpose: loadable down counter that saturates at zero.
// Ports:
//   clk, resetSwitch : clock, asynchronous active-low reset
//   load, loadValue  : load the counter (takes priority over counting)
//   countEn          : counting tick; decrements while nonzero
//   done             : countEn seen while the counter is already zero
module pong_tick_timer
  import pong_pkg::*;
(
  input  logic               clk,
  input  logic               resetSwitch,
  input  logic               load,
  input  logic [DELAY_W-1:0] loadValue,
  input  logic               countEn,
  output logic               done
);

  logic [DELAY_W-1:0] count;

  assign done = countEn && (count == '0);

  always_ff @(posedge clk or negedge resetSwitch) begin
    if (!resetSwitch) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (countEn && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pong_match_controller.sv
// rtl/pong_match_controller.sv - match-level sequencer for the Pong datapath
//
// Purpose: sequences serve, rally, point freeze and game over; keeps scores.
// Ports:
//   clk         : system clock
//   resetSwitch : asynchronous active-low reset
//   bus         : slave side of pong_match_controller_if (requests in, status out)
module pong_match_controller
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 5,
  parameter int SCORE_W     = 3,
  parameter int SERVE_DELAY = 60,
  parameter int POINT_DELAY = 90
) (
  input logic                    clk,
  input logic                    resetSwitch,
  pong_match_controller_if.slave bus
);

  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
  localparam logic [DELAY_W-1:0] SERVE_LOAD = DELAY_W'(SERVE_DELAY);
  localparam logic [DELAY_W-1:0] POINT_LOAD = DELAY_W'(POINT_DELAY);

  gameState_t         state, stateNext;
  logic [SCORE_W-1:0] p1Score, p1Next, p2Score, p2Next;
  logic [1:0]         winnerR, winnerNext;
  logic               serveDir, serveDirNext;
  logic               ballLoadR, ballLoadNext;
  logic               countTick, timerLoad, timerDone;
  logic [DELAY_W-1:0] timerValue;

  assign countTick = bus.tickEn && !bus.pauseSwitch;

  // The timer only counts in the two waiting states so its done flag can
  // never leak into other states.
  pong_tick_timer timer (
    .clk         (clk),
    .resetSwitch (resetSwitch),
    .load        (timerLoad),
    .loadValue   (timerValue),
    .countEn     (countTick && (state == SERVE || state == POINT)),
    .done        (timerDone)
  );

  always_ff @(posedge clk or negedge resetSwitch) begin
    if (!resetSwitch) begin
      state     <= IDLE;
      p1Score   <= '0;
      p2Score   <= '0;
      winnerR   <= WIN_NONE;
      serveDir  <= 1'b1;
      ballLoadR <= 1'b0;
    end else begin
      state     <= stateNext;
      p1Score   <= p1Next;
      p2Score   <= p2Next;
      winnerR   <= winnerNext;
      serveDir  <= serveDirNext;
      ballLoadR <= ballLoadNext;
    end
  end

  always_comb begin
    stateNext    = state;
    p1Next       = p1Score;
    p2Next       = p2Score;
    winnerNext   = winnerR;
    serveDirNext = serveDir;
    ballLoadNext = 1'b0;
    timerLoad    = 1'b0;
    timerValue   = SERVE_LOAD;

    // Start (or restart) wins over everything, including a same-cycle miss.
    if (bus.startPulse) begin
      stateNext    = SERVE;
      p1Next       = '0;
      p2Next       = '0;
      winnerNext   = WIN_NONE;
      serveDirNext = 1'b1;
      ballLoadNext = 1'b1;
      timerLoad    = 1'b1;
    end else begin
      case (state)
        SERVE: begin
          if (timerDone) stateNext = RALLY;
        end
        RALLY: begin
          // missLeft is checked first so a simultaneous missRight is dropped.
          if (bus.missLeft) begin
            p2Next       = p2Score + 1'b1;
            serveDirNext = 1'b0;
            if (p2Next == WIN_VAL) begin
              stateNext  = GAME_OVER;
              winnerNext = WIN_P2;
            end else begin
              stateNext  = POINT;
              timerLoad  = 1'b1;
              timerValue = POINT_LOAD;
            end
          end else if (bus.missRight) begin
            p1Next       = p1Score + 1'b1;
            serveDirNext = 1'b1;
            if (p1Next == WIN_VAL) begin
              stateNext  = GAME_OVER;
              winnerNext = WIN_P1;
            end else begin
              stateNext  = POINT;
              timerLoad  = 1'b1;
              timerValue = POINT_LOAD;
            end
          end
        end
        POINT: begin
          if (timerDone) begin
            stateNext    = SERVE;
            ballLoadNext = 1'b1;
            timerLoad    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.moveEn        = bus.tickEn && (state == RALLY) && !bus.pauseSwitch;
  assign bus.ballLoad      = ballLoadR;
  assign bus.serveDirRight = serveDir;
  assign bus.player1Score  = p1Score;
  assign bus.player2Score  = p2Score;
  assign bus.winner        = winnerR;
  assign bus.gameState     = state;

endmodule

// File: tb/tb_pong_match_controller.sv
// tb/tb_pong_match_controller.sv - directed testbench for pong_match_controller
module tb_pong_match_controller;
  import pong_pkg::*;

  localparam int SCORE_W     = 3;
  localparam int WIN_SCORE   = 5;
  localparam int SERVE_DELAY = 2;
  localparam int POINT_DELAY = 3;

  logic clk = 1'b0;
  logic resetSwitch = 1'b0;
  int compared = 0;
  int mismatched = 0;

  pong_match_controller_if #(.SCORE_W(SCORE_W)) bus ();

  pong_match_controller #(
    .WIN_SCORE   (WIN_SCORE),
    .SCORE_W     (SCORE_W),
    .SERVE_DELAY (SERVE_DELAY),
    .POINT_DELAY (POINT_DELAY)
  ) dut (
    .clk         (clk),
    .resetSwitch (resetSwitch),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doTicks(input int n);
    for (int k = 0; k < n; k++) begin
      bus.tickEn = 1'b1;
      step();
      bus.tickEn = 1'b0;
    end
  endtask

  // POINT countdown back to SERVE, then SERVE countdown into RALLY.
  task automatic pointToRally();
    doTicks(POINT_DELAY + 1);
    doTicks(SERVE_DELAY + 1);
  endtask

  task automatic test_reset();
    #12;
    compared++;
    if (bus.gameState !== 3'd0) begin mismatched++; $display("FAIL reset_state got %0d want 0", bus.gameState); end
    compared++;
    if (bus.player1Score !== 3'd0 || bus.player2Score !== 3'd0) begin mismatched++; $display("FAIL reset_scores got %0d:%0d want 0:0", bus.player1Score, bus.player2Score); end
    compared++;
    if (bus.winner !== 2'b00 || bus.ballLoad !== 1'b0 || bus.serveDirRight !== 1'b1 || bus.moveEn !== 1'b0) begin
      mismatched++; $display("FAIL reset_outputs got win=%b load=%b dir=%b move=%b want 00 0 1 0", bus.winner, bus.ballLoad, bus.serveDirRight, bus.moveEn);
    end
    @(posedge clk);
    #1 resetSwitch = 1'b1;
    step();
  endtask

  task automatic test_serve();
    bus.startPulse = 1'b1;
    step();
    bus.startPulse = 1'b0;
    compared++;
    if (bus.gameState !== 3'd1 || bus.ballLoad !== 1'b1) begin mismatched++; $display("FAIL serve_entry got state=%0d load=%b want 1 1", bus.gameState, bus.ballLoad); end
    bus.missLeft = 1'b1;
    step();
    bus.missLeft = 1'b0;
    compared++;
    if (bus.ballLoad !== 1'b0) begin mismatched++; $display("FAIL serve_load_width got %b want 0", bus.ballLoad); end
    compared++;
    if (bus.gameState !== 3'd1 || bus.player2Score !== 3'd0) begin mismatched++; $display("FAIL serve_miss_ignored got state=%0d p2=%0d want 1 0", bus.gameState, bus.player2Score); end
    doTicks(2);
    compared++;
    if (bus.gameState !== 3'd1) begin mismatched++; $display("FAIL serve_after2 got %0d want 1", bus.gameState); end
    bus.tickEn = 1'b1;
    #1;
    compared++;
    if (bus.moveEn !== 1'b0) begin mismatched++; $display("FAIL serve_move got %b want 0", bus.moveEn); end
    @(posedge clk);
    #1 bus.tickEn = 1'b0;
    compared++;
    if (bus.gameState !== 3'd2) begin mismatched++; $display("FAIL serve_to_rally got %0d want 2", bus.gameState); end
    bus.tickEn = 1'b1;
    #1;
    compared++;
    if (bus.moveEn !== 1'b1) begin mismatched++; $display("FAIL rally_move got %b want 1", bus.moveEn); end
    @(posedge clk);
    #1 bus.tickEn = 1'b0;
  endtask

  task automatic test_point();
    bus.missRight = 1'b1;
    step();
    bus.missRight = 1'b0;
    compared++;
    if (bus.player1Score !== 3'd1 || bus.serveDirRight !== 1'b1 || bus.gameState !== 3'd3) begin
      mismatched++; $display("FAIL point_entry got p1=%0d dir=%b state=%0d want 1 1 3", bus.player1Score, bus.serveDirRight, bus.gameState);
    end
    doTicks(POINT_DELAY);
    compared++;
    if (bus.gameState !== 3'd3) begin mismatched++; $display("FAIL point_hold got %0d want 3", bus.gameState); end
    doTicks(1);
    compared++;
    if (bus.gameState !== 3'd1 || bus.ballLoad !== 1'b1 || bus.player1Score !== 3'd1) begin
      mismatched++; $display("FAIL point_to_serve got state=%0d load=%b p1=%0d want 1 1 1", bus.gameState, bus.ballLoad, bus.player1Score);
    end
    step();
    compared++;
    if (bus.ballLoad !== 1'b0) begin mismatched++; $display("FAIL point_load_width got %b want 0", bus.ballLoad); end
  endtask

  task automatic test_pause();
    bus.pauseSwitch = 1'b1;
    doTicks(10);
    compared++;
    if (bus.gameState !== 3'd1) begin mismatched++; $display("FAIL pause_frozen got %0d want 1", bus.gameState); end
    bus.pauseSwitch = 1'b0;
    doTicks(SERVE_DELAY);
    compared++;
    if (bus.gameState !== 3'd1) begin mismatched++; $display("FAIL pause_resume_hold got %0d want 1", bus.gameState); end
    doTicks(1);
    compared++;
    if (bus.gameState !== 3'd2) begin mismatched++; $display("FAIL pause_resume_rally got %0d want 2", bus.gameState); end
    bus.pauseSwitch = 1'b1;
    bus.tickEn = 1'b1;
    #1;
    compared++;
    if (bus.moveEn !== 1'b0) begin mismatched++; $display("FAIL pause_move got %b want 0", bus.moveEn); end
    bus.tickEn = 1'b0;
  endtask

  // Pause is still held here: misses must be taken regardless.
  task automatic test_same_cycle_miss();
    bus.missLeft = 1'b1;
    bus.missRight = 1'b1;
    step();
    bus.missLeft = 1'b0;
    bus.missRight = 1'b0;
    bus.pauseSwitch = 1'b0;
    compared++;
    if (bus.player2Score !== 3'd1 || bus.player1Score !== 3'd1 || bus.serveDirRight !== 1'b0 || bus.gameState !== 3'd3) begin
      mismatched++; $display("FAIL both_miss got p1=%0d p2=%0d dir=%b state=%0d want 1 1 0 3", bus.player1Score, bus.player2Score, bus.serveDirRight, bus.gameState);
    end
  endtask

  task automatic test_start_priority();
    pointToRally();
    bus.startPulse = 1'b1;
    bus.missLeft = 1'b1;
    step();
    bus.startPulse = 1'b0;
    bus.missLeft = 1'b0;
    compared++;
    if (bus.player1Score !== 3'd0 || bus.player2Score !== 3'd0 || bus.gameState !== 3'd1 || bus.ballLoad !== 1'b1 || bus.serveDirRight !== 1'b1) begin
      mismatched++; $display("FAIL start_priority got p1=%0d p2=%0d state=%0d load=%b dir=%b want 0 0 1 1 1",
        bus.player1Score, bus.player2Score, bus.gameState, bus.ballLoad, bus.serveDirRight);
    end
  endtask

  task automatic test_win();
    doTicks(SERVE_DELAY + 1);
    for (int i = 1; i <= WIN_SCORE; i++) begin
      bus.missLeft = 1'b1;
      step();
      bus.missLeft = 1'b0;
      compared++;
      if (bus.player2Score !== 3'(i)) begin mismatched++; $display("FAIL win_p2_%0d got %0d want %0d", i, bus.player2Score, i); end
      if (i < WIN_SCORE) begin
        compared++;
        if (bus.gameState !== 3'd3 || bus.winner !== 2'b00) begin mismatched++; $display("FAIL win_point_%0d got state=%0d win=%b want 3 00", i, bus.gameState, bus.winner); end
        pointToRally();
      end
    end
    compared++;
    if (bus.gameState !== 3'd4 || bus.winner !== 2'b10) begin mismatched++; $display("FAIL game_over got state=%0d win=%b want 4 10", bus.gameState, bus.winner); end
    doTicks(3);
    bus.missLeft = 1'b1;
    step();
    bus.missLeft = 1'b0;
    bus.missRight = 1'b1;
    step();
    bus.missRight = 1'b0;
    compared++;
    if (bus.gameState !== 3'd4 || bus.player2Score !== 3'd5 || bus.player1Score !== 3'd0 || bus.winner !== 2'b10) begin
      mismatched++; $display("FAIL game_over_hold got state=%0d p1=%0d p2=%0d win=%b want 4 0 5 10", bus.gameState, bus.player1Score, bus.player2Score, bus.winner);
    end
    bus.startPulse = 1'b1;
    step();
    bus.startPulse = 1'b0;
    compared++;
    if (bus.gameState !== 3'd1 || bus.player2Score !== 3'd0 || bus.winner !== 2'b00 || bus.ballLoad !== 1'b1 || bus.serveDirRight !== 1'b1) begin
      mismatched++; $display("FAIL restart got state=%0d p2=%0d win=%b load=%b dir=%b want 1 0 00 1 1",
        bus.gameState, bus.player2Score, bus.winner, bus.ballLoad, bus.serveDirRight);
    end
  endtask

  task automatic test_async_reset();
    doTicks(SERVE_DELAY + 1);
    for (int i = 0; i < 5; i++) begin
      bus.missRight = (i % 2 == 0);
      bus.missLeft  = (i % 2 == 1);
      step();
      bus.missRight = 1'b0;
      bus.missLeft  = 1'b0;
      pointToRally();
    end
    compared++;
    if (bus.gameState !== 3'd2 || bus.player1Score !== 3'd3 || bus.player2Score !== 3'd2) begin
      mismatched++; $display("FAIL pre_reset got state=%0d p1=%0d p2=%0d want 2 3 2", bus.gameState, bus.player1Score, bus.player2Score);
    end
    bus.tickEn = 1'b1;
    #1;
    compared++;
    if (bus.moveEn !== 1'b1) begin mismatched++; $display("FAIL pre_reset_move got %b want 1", bus.moveEn); end
    #2 resetSwitch = 1'b0;
    #1;
    compared++;
    if (bus.gameState !== 3'd0 || bus.player1Score !== 3'd0 || bus.player2Score !== 3'd0 || bus.moveEn !== 1'b0 || bus.serveDirRight !== 1'b1) begin
      mismatched++; $display("FAIL async_reset got state=%0d p1=%0d p2=%0d move=%b dir=%b want 0 0 0 0 1",
        bus.gameState, bus.player1Score, bus.player2Score, bus.moveEn, bus.serveDirRight);
    end
    bus.tickEn = 1'b0;
    step();
    resetSwitch = 1'b1;
  endtask

  initial begin
    bus.startPulse  = 1'b0;
    bus.pauseSwitch = 1'b0;
    bus.tickEn      = 1'b0;
    bus.missLeft    = 1'b0;
    bus.missRight   = 1'b0;
    test_reset();
    test_serve();
    test_point();
    test_pause();
    test_same_cycle_miss();
    test_start_priority();
    test_win();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
